// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths, the hardwired-zero register index and address/data/tag typedefs.
// Modules keep their own parameters; these defaults match the core's RV32 configuration.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_TAG_W = 4;

  // x0 is hardwired to zero and never tracked by the scoreboard
  localparam int REG_ZERO = 0;

  typedef logic [DEF_AW-1:0]    reg_addr_t;
  typedef logic [DEF_XLEN-1:0]  reg_data_t;
  typedef logic [DEF_TAG_W-1:0] reg_tag_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One registered read port: address decode, commit bypass / busy-clear compare, output register.
// Latency 1 cycle; no backpressure, a read is accepted every cycle rd_en is high.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle commit data and post-commit busy.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = 32,
  parameter int AW    = DEF_AW,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  input  logic                  cm_we,
  input  logic [AW-1:0]         cm_addr,
  input  logic [TAG_W-1:0]      cm_tag,
  input  logic [XLEN-1:0]       cm_data,
  input  logic [NREG*XLEN-1:0]  regs_flat,
  input  logic [NREG-1:0]       busy_vec,
  input  logic [NREG*TAG_W-1:0] tags_flat,
  output logic [XLEN-1:0]       data,
  output logic                  busy,
  output logic [TAG_W-1:0]      tag
);

  logic             valid;
  int               idx;
  logic [XLEN-1:0]  cur_data;
  logic             cur_busy;
  logic [TAG_W-1:0] cur_tag;
  logic [XLEN-1:0]  nxt_data;
  logic             nxt_busy;
  logic [TAG_W-1:0] nxt_tag;

`ifndef REGFILE_SB_BYPASS_EN
  // Commit inputs only matter when bypassing
  logic unused_cm;
  assign unused_cm = ^{cm_we, cm_addr, cm_tag, cm_data};
`endif

  // Decode address and pick the next output values (x0 and out-of-range read as zero)
  always_comb begin
    valid    = (int'(addr) != REG_ZERO) && (int'(addr) < NREG);
    idx      = valid ? int'(addr) : 0;
    cur_data = regs_flat[idx*XLEN +: XLEN];
    cur_busy = busy_vec[idx];
    cur_tag  = tags_flat[idx*TAG_W +: TAG_W];
    nxt_data = cur_data;
    nxt_busy = cur_busy && !flush;
    nxt_tag  = cur_tag;
`ifdef REGFILE_SB_BYPASS_EN
    if (cm_we && (cm_addr == addr)) begin
      nxt_data = cm_data;
      if (cur_busy && (cur_tag == cm_tag)) begin
        nxt_busy = 1'b0;
      end
    end
`endif
    if (!valid) begin
      nxt_data = '0;
      nxt_busy = 1'b0;
      nxt_tag  = '0;
    end
  end

  // Output register; a disabled port returns zeros
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      data <= '0;
      busy <= 1'b0;
      tag  <= '0;
    end else begin
      data <= nxt_data;
      busy <= nxt_busy;
      tag  <= nxt_tag;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with per-register busy/tag scoreboard and NRD registered read ports.
// Read latency 1 cycle; issue/commit/flush take effect at the clock edge, no backpressure.
// Optional macro REGFILE_SB_BYPASS_EN enables same-cycle commit forwarding on the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = 32,
  parameter int AW    = DEF_AW,
  parameter int TAG_W = DEF_TAG_W,
  parameter int NRD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  is_we,
  input  logic [AW-1:0]         is_addr,
  input  logic [TAG_W-1:0]      is_tag,
  input  logic                  cm_we,
  input  logic [AW-1:0]         cm_addr,
  input  logic [TAG_W-1:0]      cm_tag,
  input  logic [XLEN-1:0]       cm_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag
);

  logic [XLEN-1:0]       regs [NREG];
  logic [TAG_W-1:0]      tags [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG*XLEN-1:0]  regs_flat;
  logic [NREG*TAG_W-1:0] tags_flat;

  logic is_ok;
  logic cm_ok;
  logic cm_clr;
  int   cm_idx;

  // Qualify issue and commit; writes to x0 or beyond NREG are dropped
  always_comb begin
    is_ok  = is_we && !flush && (int'(is_addr) != REG_ZERO) && (int'(is_addr) < NREG);
    cm_ok  = cm_we && (int'(cm_addr) != REG_ZERO) && (int'(cm_addr) < NREG);
    cm_idx = cm_ok ? int'(cm_addr) : 0;
    cm_clr = cm_ok && busy[cm_idx] && (tags[cm_idx] == cm_tag);
  end

  // Register/scoreboard update: flush beats issue, issue beats commit clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
        busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (cm_ok && (int'(cm_addr) == i)) begin
          regs[i] <= cm_data;
        end
        if (flush) begin
          busy[i] <= 1'b0;
        end else if (is_ok && (int'(is_addr) == i)) begin
          busy[i] <= 1'b1;
          tags[i] <= is_tag;
        end else if (cm_clr && (int'(cm_addr) == i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[g*XLEN +: XLEN]   = regs[g];
      assign tags_flat[g*TAG_W +: TAG_W] = tags[g];
    end

    for (g = 0; g < NRD; g++) begin : g_rd
      regfile_sb_rdport #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .AW    (AW),
        .TAG_W (TAG_W)
      ) u_rdport (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .en        (rd_en[g]),
        .addr      (rd_addr[g*AW +: AW]),
        .cm_we     (cm_we),
        .cm_addr   (cm_addr),
        .cm_tag    (cm_tag),
        .cm_data   (cm_data),
        .regs_flat (regs_flat),
        .busy_vec  (busy),
        .tags_flat (tags_flat),
        .data      (rd_data[g*XLEN +: XLEN]),
        .busy      (rd_busy[g]),
        .tag       (rd_tag[g*TAG_W +: TAG_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: hand-computed expectations per scenario task.
module tb_regfile_sb;
  import regfile_pkg::*;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        is_we;
  logic [4:0]  is_addr;
  logic [3:0]  is_tag;
  logic        cm_we;
  logic [4:0]  cm_addr;
  logic [3:0]  cm_tag;
  logic [31:0] cm_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;

  // Per-port view {data, busy, tag}
  logic [36:0] p0, p1;
  assign p0 = {rd_data[31:0],  rd_busy[0], rd_tag[3:0]};
  assign p1 = {rd_data[63:32], rd_busy[1], rd_tag[7:4]};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .is_we   (is_we),
    .is_addr (is_addr),
    .is_tag  (is_tag),
    .cm_we   (cm_we),
    .cm_addr (cm_addr),
    .cm_tag  (cm_tag),
    .cm_data (cm_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .rd_tag  (rd_tag)
  );

  task automatic idle();
    flush = 1'b0; is_we = 1'b0; is_addr = '0; is_tag = '0;
    cm_we = 1'b0; cm_addr = '0; cm_tag = '0; cm_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a, input int t);
    is_we = 1'b1; is_addr = 5'(a); is_tag = 4'(t);
  endtask

  task automatic commit(input int a, input int t, input logic [31:0] d);
    cm_we = 1'b1; cm_addr = 5'(a); cm_tag = 4'(t); cm_data = d;
  endtask

  task automatic read(input bit e0, input int a0, input bit e1, input int a1);
    rd_en = {e1, e0};
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic test_reset();
    reg_addr_t a;
    idle();
    rst = 1'b0;
    read(1, 5, 1, 6);
    tick(); tick();
    n_cmp++;
    if ({p1, p0} !== 74'd0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0", {p1, p0});
    end
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      a = reg_addr_t'(i);
      read(1, int'(a), 1, int'(a));
      tick();
      n_cmp++;
      if ({p1, p0} !== 74'd0) begin
        n_bad++;
        $display("FAIL reset_read x%0d: got %h want 0", i, {p1, p0});
      end
    end
    idle();
  endtask

  task automatic test_commit_bypass();
    idle(); issue(5, 3); tick();
    idle(); commit(5, 3, 32'hDEADBEEF); read(1, 5, 0, 0); tick();
    n_cmp++;
    if (p0 !== (BYP ? {32'hDEADBEEF, 1'b0, 4'd3} : {32'h0, 1'b1, 4'd3})) begin
      n_bad++;
      $display("FAIL commit_read_same: got %h want %h", p0,
               BYP ? {32'hDEADBEEF, 1'b0, 4'd3} : {32'h0, 1'b1, 4'd3});
    end
    idle(); read(1, 5, 0, 0); tick();
    n_cmp++;
    if (p0 !== {32'hDEADBEEF, 1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL commit_read_next: got %h want %h", p0, {32'hDEADBEEF, 1'b0, 4'd3});
    end
    idle(); read(0, 5, 0, 0); tick();
    n_cmp++;
    if (p0 !== 37'd0) begin
      n_bad++;
      $display("FAIL rd_en_low: got %h want 0", p0);
    end
    idle();
  endtask

  task automatic test_stale_commit();
    idle(); issue(7, 2); tick();
    idle(); issue(7, 9); tick();
    idle(); commit(7, 2, 32'h11); tick();
    idle(); read(1, 7, 1, 7); tick();
    n_cmp++;
    if (p0 !== {32'h11, 1'b1, 4'd9}) begin
      n_bad++;
      $display("FAIL stale_p0: got %h want %h", p0, {32'h11, 1'b1, 4'd9});
    end
    n_cmp++;
    if (p1 !== {32'h11, 1'b1, 4'd9}) begin
      n_bad++;
      $display("FAIL stale_p1: got %h want %h", p1, {32'h11, 1'b1, 4'd9});
    end
    idle();
  endtask

  task automatic test_issue_commit_same();
    idle(); issue(3, 4); commit(3, 1, 32'h22); read(0, 0, 1, 3); tick();
    n_cmp++;
    if (p1 !== {(BYP ? 32'h22 : 32'h0), 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL iss_cm_same: got %h want %h", p1, {(BYP ? 32'h22 : 32'h0), 1'b0, 4'd0});
    end
    idle(); read(0, 0, 1, 3); tick();
    n_cmp++;
    if (p1 !== {32'h22, 1'b1, 4'd4}) begin
      n_bad++;
      $display("FAIL iss_cm_next: got %h want %h", p1, {32'h22, 1'b1, 4'd4});
    end
    idle();
  endtask

  task automatic test_flush();
    idle(); issue(8, 1); tick();
    idle(); issue(9, 2); tick();
    idle(); issue(10, 3); tick();
    idle(); flush = 1'b1; issue(11, 5); read(1, 8, 1, 9); tick();
    n_cmp++;
    if ({p1, p0} !== {32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL flush_same: got %h want %h", {p1, p0}, {32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd1});
    end
    idle(); read(1, 8, 1, 9); tick();
    n_cmp++;
    if ({p1, p0} !== {32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL flush_x8_x9: got %h want %h", {p1, p0}, {32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd1});
    end
    idle(); read(1, 10, 1, 11); tick();
    n_cmp++;
    if ({p1, p0} !== {32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL flush_x10_x11: got %h want %h", {p1, p0}, {32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3});
    end
    idle();
  endtask

  task automatic test_x0();
    idle(); commit(0, 0, 32'hFFFFFFFF); issue(0, 6); tick();
    idle(); read(1, 0, 1, 0); tick();
    n_cmp++;
    if ({p1, p0} !== 74'd0) begin
      n_bad++;
      $display("FAIL x0_read: got %h want 0", {p1, p0});
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); commit(4, 0, 32'h44); tick();
    idle(); read(1, 4, 0, 0); tick();
    n_cmp++;
    if (p0 !== {32'h44, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL x4_before_rst: got %h want %h", p0, {32'h44, 1'b0, 4'd0});
    end
    idle(); rst = 1'b0; commit(4, 0, 32'h55); issue(6, 7); read(1, 4, 1, 5); tick();
    n_cmp++;
    if ({p1, p0} !== 74'd0) begin
      n_bad++;
      $display("FAIL rst_mid_out: got %h want 0", {p1, p0});
    end
    idle(); rst = 1'b1; tick();
    read(1, 4, 1, 6); tick();
    n_cmp++;
    if ({p1, p0} !== 74'd0) begin
      n_bad++;
      $display("FAIL x4_x6_after_rst: got %h want 0", {p1, p0});
    end
    idle(); read(1, 7, 1, 5); tick();
    n_cmp++;
    if ({p1, p0} !== 74'd0) begin
      n_bad++;
      $display("FAIL x7_x5_after_rst: got %h want 0", {p1, p0});
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_commit_bypass();
    test_stale_commit();
    test_issue_commit_same();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
